spi_master: RTL and testbench

- Initiator end of the 8-bit SPI link; drives spi_clk, spi_ss and spi_out (MOSI), and samples spi_in (MISO).
- Talks to the spi_slave block or to external SPI peripherals.
- Host side is a start/busy/done handshake with parallel bus_in/bus_out bytes.
- Supports all four CPOL/CPHA modes; SCK rate is set by a programmable divider of clk.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master.sv | 158 +++++++++++++++
 tb/tb_spi_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and constants for spi_master and spi_slave
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int SPI_BITS = 8;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator, one tick every (top+1) enabled cycles
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             ena,
    input  logic [DIV_W-1:0] top,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (ena) begin
            if (cnt == top) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = ena && !clear && (cnt == top);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI initiator, all CPOL/CPHA modes, optional SPI_MASTER_LSB_FIRST_EN
module spi_master
    import spi_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int BITS  = SPI_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [BITS-1:0]  bus_in,
    output logic [BITS-1:0]  bus_out,
    output logic             busy,
    output logic             done,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             spi_clk_polarity,
    input  logic             spi_clk_phase,
    output logic             spi_clk,
    output logic             spi_ss,
    output logic             spi_out,
    input  logic             spi_in
);

    localparam int EW = $clog2(2 * BITS);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * BITS - 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    spi_state_t       state_q;
    spi_state_t       state_d;
    logic             cpol_q;
    logic             cpha_q;
    logic [DIV_W-1:0] div_q;
    logic [BITS-1:0]  shreg;
    logic [BITS-1:0]  rx;
    logic [BITS-1:0]  bus_out_q;
    logic [EW-1:0]    edge_cnt;
    logic             sck;
    logic             done_q;
    logic             tick;
    logic             leading;
    logic             do_shift;
    logic             do_sample;

    // Counter is held clear in IDLE so SETUP always starts a fresh half-period.
    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .ena   (ena),
        .top   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        leading   = ~edge_cnt[0];
        do_shift  = 1'b0;
        do_sample = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    // CPHA=1 already presented the first bit in SETUP, so skip the first leading shift.
                    if (cpha_q) begin
                        do_sample = !leading;
                        do_shift  = leading && (edge_cnt != '0);
                    end else begin
                        do_sample = leading;
                        do_shift  = !leading;
                    end
                    if (edge_cnt == LAST_EDGE) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            shreg     <= '0;
            rx        <= '0;
            bus_out_q <= '0;
            edge_cnt  <= '0;
            sck       <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ena) begin
                if (state_q == IDLE && start) begin
                    shreg    <= bus_in;
                    cpol_q   <= spi_clk_polarity;
                    cpha_q   <= spi_clk_phase;
                    div_q    <= clk_div;
                    edge_cnt <= '0;
                    sck      <= 1'b0;
                end
                if (state_q == SHIFT && tick) begin
                    sck      <= ~sck;
                    edge_cnt <= (edge_cnt == LAST_EDGE) ? '0 : edge_cnt + 1'b1;
                end
                if (do_shift) begin
                    shreg <= LSB_FIRST ? {1'b0, shreg[BITS-1:1]} : {shreg[BITS-2:0], 1'b0};
                end
                if (do_sample) begin
                    rx <= LSB_FIRST ? {spi_in, rx[BITS-1:1]} : {rx[BITS-2:0], spi_in};
                end
                if (state_q == HOLD && tick) begin
                    bus_out_q <= rx;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    // Slave select drops out of the transfer in the same cycle reset is raised.
    assign spi_ss  = (state_q == IDLE) || rst;
    assign spi_clk = (state_q == IDLE || rst) ? spi_clk_polarity : (sck ^ cpol_q);
    assign spi_out = (state_q == IDLE) ? 1'b0 : (LSB_FIRST ? shreg[0] : shreg[BITS-1]);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign bus_out = bus_out_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized bench for spi_master against a behavioural SPI slave model
module tb_spi_master;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       busy;
    logic       done;
    logic [7:0] clk_div;
    logic       cpol;
    logic       cpha;
    logic       spi_clk;
    logic       spi_ss;
    logic       spi_out;
    logic       spi_in;
    logic       loop_en;
    logic       slave_miso;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign spi_in = loop_en ? spi_out : slave_miso;

    spi_master #(
        .DIV_W (8),
        .BITS  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .start            (start),
        .bus_in           (bus_in),
        .bus_out          (bus_out),
        .busy             (busy),
        .done             (done),
        .clk_div          (clk_div),
        .spi_clk_polarity (cpol),
        .spi_clk_phase    (cpha),
        .spi_clk          (spi_clk),
        .spi_ss           (spi_ss),
        .spi_out          (spi_out),
        .spi_in           (spi_in)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit i of the serial stream maps to byte position i (LSB first) or 7-i (MSB first).
    function automatic int bit_pos(input int i);
        return LSB ? i : 7 - i;
    endfunction

    task automatic run_xfer(input logic [1:0] mode, input logic [7:0] div, input logic [7:0] mb,
                            input logic [7:0] sb, input bit lp, input bit half, input int mid);
        int         hp;
        int         exp_c;
        int         done_c = -1;
        int         n_done = 0;
        int         rises = 0;
        int         ss_low = 0;
        int         n_tr = 0;
        int         last_tr = 0;
        int         hp_bad = 0;
        int         s_idx = 0;
        int         s_cap = 0;
        logic [7:0] s_rx = 8'h00;
        logic [7:0] sb_v;
        logic       first_bit = 1'b0;
        logic       prev_clk;
        logic       prev_ss = 1'b1;
        logic       lead;

        sb_v  = sb;
        hp    = (half ? 2 : 1) * (int'(div) + 1);
        exp_c = 18 * hp + 1;
        @(negedge clk);
        cpol       = mode[1];
        cpha       = mode[0];
        clk_div    = div;
        bus_in     = mb;
        loop_en    = lp;
        ena        = 1'b1;
        start      = 1'b1;
        slave_miso = 1'b0;
        prev_clk   = mode[1];
        for (int c = 1; c <= exp_c + 3; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (!spi_ss) ss_low++;
            if (!spi_ss && prev_ss && !mode[0]) begin
                slave_miso = sb_v[bit_pos(s_idx)];
                s_idx++;
            end
            if (spi_clk !== prev_clk) begin
                if (spi_clk) rises++;
                if (n_tr > 0 && (c - last_tr) != hp) hp_bad++;
                n_tr++;
                last_tr = c;
                if (!spi_ss) begin
                    lead = (spi_clk != mode[1]);
                    if (lead == mode[0]) begin
                        if (s_idx < 8) begin
                            slave_miso = sb_v[bit_pos(s_idx)];
                            s_idx++;
                        end
                    end else if (s_cap < 8) begin
                        if (s_cap == 0) first_bit = spi_out;
                        s_rx[bit_pos(s_cap)] = spi_out;
                        s_cap++;
                    end
                end
            end
            prev_clk = spi_clk;
            prev_ss  = spi_ss;
            start  = (c == mid);
            bus_in = (c == mid) ? 8'hFF : mb;
            ena    = half ? (c % 2 == 0) : 1'b1;
            if (mid >= 0) begin
                clk_div = (c < exp_c - 1) ? div + 8'd1 : div;
                cpha    = (c < exp_c - 1) ? ~mode[0] : mode[0];
            end
        end
        check("done_cycle", done_c, exp_c);
        check("done_count", n_done, 1);
        check("bus_out", int'(bus_out), lp ? int'(mb) : int'(sb));
        check("sck_rises", rises, 8);
        check("ss_low_cycles", ss_low, exp_c - 1);
        check("half_period", hp_bad, 0);
        check("busy_after", int'(busy), 0);
        check("sck_idle", int'(spi_clk), int'(mode[1]));
        if (!lp) begin
            check("slave_rx", int'(s_rx), int'(mb));
            check("mosi_first", int'(first_bit), LSB ? int'(mb[0]) : int'(mb[7]));
        end
    endtask

    task automatic reset_mid();
        int   n_tr = 0;
        int   n_done = 0;
        logic prev = 1'b0;
        @(negedge clk);
        cpol    = 1'b0;
        cpha    = 1'b0;
        clk_div = 8'd1;
        bus_in  = 8'h96;
        loop_en = 1'b1;
        ena     = 1'b1;
        start   = 1'b1;
        for (int c = 0; c < 200 && n_tr < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (spi_clk !== prev) n_tr++;
            prev = spi_clk;
        end
        check("rst_edge5_seen", n_tr, 5);
        rst = 1'b1;
        #1;
        check("rst_ss_now", int'(spi_ss), 1);
        @(negedge clk);
        check("rst_ss", int'(spi_ss), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_bus_out", int'(bus_out), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_no_done", n_done, 0);
        check("rst_mosi", int'(spi_out), 0);
    endtask

    initial begin
        rst        = 1'b1;
        ena        = 1'b1;
        start      = 1'b0;
        bus_in     = 8'h00;
        clk_div    = 8'd0;
        cpol       = 1'b1;
        cpha       = 1'b0;
        loop_en    = 1'b0;
        slave_miso = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ss", int'(spi_ss), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_bus_out", int'(bus_out), 0);
        check("reset_mosi", int'(spi_out), 0);
        check("reset_sck_cpol1", int'(spi_clk), 1);
        rst  = 1'b0;
        cpol = 1'b0;
        @(negedge clk);
        check("idle_sck_cpol0", int'(spi_clk), 0);

        run_xfer(2'b00, 8'd0, 8'hA5, 8'h00, 1'b1, 1'b0, -1);
        run_xfer(2'b11, 8'd3, 8'h3C, 8'hC3, 1'b0, 1'b0, -1);
        run_xfer(2'b01, 8'd1, 8'h5A, 8'h81, 1'b0, 1'b0, -1);
        run_xfer(2'b10, 8'd2, 8'h5A, 8'h81, 1'b0, 1'b0, -1);
        run_xfer(2'b00, 8'd1, 8'h69, 8'h0F, 1'b0, 1'b0, 10);
        reset_mid();
        run_xfer(2'b00, 8'd0, 8'h01, 8'h7E, 1'b0, 1'b0, -1);
        run_xfer(2'b00, 8'd0, 8'h01, 8'hB2, 1'b0, 1'b1, -1);

        for (int i = 0; i < 24; i++) begin
            run_xfer(2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 15)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
